// File: rtl/csla32_share_arb.sv
// Two-requester round-robin front end sharing one 32-bit carry-select adder.
// Optional signed-overflow output is enabled by defining CSLA32_ARB_OVF_EN.

module carry_select_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [8:0] w_c;

  assign w_c[0] = cin;

  // Each 4-bit block precomputes both carry-in cases; the incoming carry only selects.
  for (genvar k = 0; k < 8; k++) begin : g_blk
    logic [4:0] w_s0;
    logic [4:0] w_s1;
    assign w_s0 = {1'b0, a[4*k+3:4*k]} + {1'b0, b[4*k+3:4*k]};
    assign w_s1 = w_s0 + 5'd1;
    assign sum[4*k+3:4*k] = w_c[k] ? w_s1[3:0] : w_s0[3:0];
    assign w_c[k+1] = w_c[k] ? w_s1[4] : w_s0[4];
  end

  assign cout = w_c[8];
endmodule

module csla32_share_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [1:0]  req_cin,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout
`ifdef CSLA32_ARB_OVF_EN
  ,
  output logic        rsp_ovf
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic        r_prio;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_cin;
  logic        r_g;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_any;
  logic        w_win;

  assign w_any = |req_valid;
  assign w_win = (req_valid == 2'b11) ? r_prio : req_valid[1];

  always_comb begin
    req_ready = 2'b00;
    if (!rst && r_state == S_IDLE && w_any)
      req_ready = w_win ? 2'b10 : 2'b01;
  end

  carry_select_adder_32bit u_add (
    .a    (r_a),
    .b    (r_b),
    .cin  (r_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Operand capture needs no reset: it is only consumed after a fresh handshake.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_IDLE && w_any) begin
      r_a   <= w_win ? req_a[63:32] : req_a[31:0];
      r_b   <= w_win ? req_b[63:32] : req_b[31:0];
      r_cin <= req_cin[w_win];
      r_g   <= w_win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_prio    <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_sum   <= 32'd0;
      rsp_cout  <= 1'b0;
`ifdef CSLA32_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            // Priority only rotates when there was real contention.
            if (req_valid == 2'b11)
              r_prio <= ~w_win;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_sum   <= w_sum;
          rsp_cout  <= w_cout;
`ifdef CSLA32_ARB_OVF_EN
          rsp_ovf   <= (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
`endif
          rsp_valid <= r_g ? 2'b10 : 2'b01;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[r_g]) begin
            rsp_valid <= 2'b00;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csla32_share_arb.sv
// Table-driven, scoreboard-checked bench for csla32_share_arb.
// Overflow checks are compiled in when CSLA32_ARB_OVF_EN is defined.

module tb_csla32_share_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_cin;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_sum;
  logic        rsp_cout;
`ifdef CSLA32_ARB_OVF_EN
  logic        rsp_ovf;
`endif

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] a0, b0, a1, b1;
    logic        c0, c1;
    logic        expG;
    logic [31:0] expSum;
    logic        expCout;
    logic        expOvf;
    int          hold;
    logic        wrong;
  } vec_t;

  typedef struct {
    logic        g;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  csla32_share_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef CSLA32_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mkVec(input logic [1:0] valid,
                                 input logic [31:0] a0, input logic [31:0] b0, input logic c0,
                                 input logic [31:0] a1, input logic [31:0] b1, input logic c1,
                                 input logic expG, input logic [31:0] expSum, input logic expCout,
                                 input logic expOvf, input int hold, input logic wrong);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.b0 = b0; v.c0 = c0;
    v.a1 = a1; v.b1 = b1; v.c1 = c1;
    v.expG = expG; v.expSum = expSum; v.expCout = expCout; v.expOvf = expOvf;
    v.hold = hold; v.wrong = wrong;
    return v;
  endfunction

  task automatic checkHeld(input string tag, input exp_t e);
    checkOutput({tag, "_valid"}, {62'd0, rsp_valid}, e.g ? 64'd2 : 64'd1);
    checkOutput({tag, "_sum"}, {32'd0, rsp_sum}, {32'd0, e.sum});
    checkOutput({tag, "_cout"}, {63'd0, rsp_cout}, {63'd0, e.cout});
    checkOutput({tag, "_req_ready"}, {62'd0, req_ready}, 64'd0);
`ifdef CSLA32_ARB_OVF_EN
    checkOutput({tag, "_ovf"}, {63'd0, rsp_ovf}, {63'd0, e.ovf});
`endif
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns just after
  // the edge on which the response was released.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    exp_t got;
    logic [1:0] grantHot;
    req_valid = v.valid;
    req_a     = {v.a1, v.a0};
    req_b     = {v.b1, v.b0};
    req_cin   = {v.c1, v.c0};
    grantHot  = v.expG ? 2'b10 : 2'b01;
    @(negedge clk);
    checkOutput("idle_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    checkOutput("grant", {62'd0, req_ready}, {62'd0, grantHot});
    e.g = v.expG; e.sum = v.expSum; e.cout = v.expCout; e.ovf = v.expOvf;
    sb.push_back(e);
    @(posedge clk); #1;
    // Scramble operands after the handshake to catch any re-sampling.
    req_a   = {$urandom, $urandom};
    req_b   = {$urandom, $urandom};
    req_cin = 2'($urandom_range(0, 3));
    if (v.valid != 2'b11) req_valid = 2'b00;
    @(negedge clk);
    checkOutput("exec_req_ready", {62'd0, req_ready}, 64'd0);
    checkOutput("exec_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    rsp_ready = (v.hold == 0) ? grantHot : (v.wrong ? ~grantHot : 2'b00);
    @(negedge clk);
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 64'd1, 64'd0);
      got = e;
    end else begin
      got = sb.pop_front();
    end
    checkHeld("resp", got);
    for (int i = 1; i <= v.hold; i++) begin
      @(posedge clk); #1;
      if (i == v.hold) rsp_ready = grantHot;
      @(negedge clk);
      checkHeld("hold", got);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    req_a = '0; req_b = '0; req_cin = '0;
    rsp_ready = 2'b00;

    vecs[0]  = mkVec(2'b01, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b0, 32'h00000000, 1'b1, 1'b0, 0, 1'b0);
    vecs[1]  = mkVec(2'b11, 32'h00000001, 32'h00000002, 1'b0, 32'h12345678, 32'h0000FFFF, 1'b1,
                     1'b0, 32'h00000003, 1'b0, 1'b0, 0, 1'b0);
    vecs[2]  = mkVec(2'b11, 32'h00000001, 32'h00000002, 1'b0, 32'h12345678, 32'h0000FFFF, 1'b1,
                     1'b1, 32'h12355678, 1'b0, 1'b0, 5, 1'b1);
    vecs[3]  = mkVec(2'b11, 32'h00000001, 32'h00000002, 1'b0, 32'h12345678, 32'h0000FFFF, 1'b1,
                     1'b0, 32'h00000003, 1'b0, 1'b0, 0, 1'b0);
    vecs[4]  = mkVec(2'b11, 32'h00000001, 32'h00000002, 1'b0, 32'h12345678, 32'h0000FFFF, 1'b1,
                     1'b1, 32'h12355678, 1'b0, 1'b0, 0, 1'b0);
    vecs[5]  = mkVec(2'b10, 32'h0, 32'h0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0,
                     1'b1, 32'h80000000, 1'b0, 1'b1, 0, 1'b0);
    vecs[6]  = mkVec(2'b01, 32'h80000000, 32'h80000000, 1'b0, 32'h0, 32'h0, 1'b0,
                     1'b0, 32'h00000000, 1'b1, 1'b1, 3, 1'b0);
    vecs[7]  = mkVec(2'b10, 32'h0, 32'h0, 1'b0, 32'h00000005, 32'hFFFFFFFF, 1'b0,
                     1'b1, 32'h00000004, 1'b1, 1'b0, 0, 1'b0);
    vecs[8]  = mkVec(2'b11, 32'hDEADBEEF, 32'h01234567, 1'b1, 32'h00000001, 32'hFFFFFFFF, 1'b1,
                     1'b0, 32'hDFD10457, 1'b0, 1'b0, 0, 1'b0);
    vecs[9]  = mkVec(2'b11, 32'hDEADBEEF, 32'h01234567, 1'b1, 32'h00000001, 32'hFFFFFFFF, 1'b1,
                     1'b1, 32'h00000001, 1'b1, 1'b0, 2, 1'b1);
    vecs[10] = mkVec(2'b10, 32'h0, 32'h0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1,
                     1'b1, 32'h00000000, 1'b1, 1'b0, 0, 1'b0);

    // Reset: requests are visible but must not be acknowledged.
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_req_ready", {62'd0, req_ready}, 64'd0);
    checkOutput("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    checkOutput("rst_rsp_sum", {32'd0, rsp_sum}, 64'd0);
    checkOutput("rst_rsp_cout", {63'd0, rsp_cout}, 64'd0);
`ifdef CSLA32_ARB_OVF_EN
    checkOutput("rst_rsp_ovf", {63'd0, rsp_ovf}, 64'd0);
`endif
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    // Quiet idle: nothing should move without a request.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("quiet_ready", {62'd0, req_ready}, 64'd0);
      checkOutput("quiet_valid", {62'd0, rsp_valid}, 64'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i]);

    // Reset during EXEC aborts; prio returns to requester 0.
    req_valid = 2'b01;
    req_a = {32'h0, 32'h11111111};
    req_b = {32'h0, 32'h22222222};
    req_cin = 2'b00;
    @(negedge clk);
    checkOutput("abort_grant", {62'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b10;
    @(negedge clk);
    checkOutput("abort_rst_ready", {62'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_no_valid", {62'd0, rsp_valid}, 64'd0);
      checkOutput("abort_sum", {32'd0, rsp_sum}, 64'd0);
      checkOutput("abort_cout", {63'd0, rsp_cout}, 64'd0);
      @(posedge clk); #1;
    end
    applyStimulus(vecs[10]);

    // Contention after reset must favour requester 0 again.
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("post_rst_prio", {62'd0, req_ready}, 64'd1);
    req_valid = 2'b00;

    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/csla32_share_arb.md
# csla32_share_arb

- Shares one `carry_select_adder_32bit` instance between two requesters.
- Each requester has a valid/ready request channel and a response channel.
- The block does round-robin arbitration, registers the operands, sequences the add, and holds the registered result until the granted requester accepts it.
- It sits between the two datapath clients and the adder. It is the only driver of the adder inputs.

## Interface
Parameters:
- none. Operand width is fixed at 32 and requester count is fixed at 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  2  bit i = requester i presents an operation.
- `req_ready`  out  2  bit i = operation of requester i accepted this cycle.
- `req_a`  in  64  operand a; requester i on bits [32i+31:32i].
- `req_b`  in  64  operand b; same packing as `req_a`.
- `req_cin`  in  2  carry-in; bit i belongs to requester i.
- `rsp_valid`  out  2  one-hot; bit i = result for requester i is held.
- `rsp_ready`  in  2  bit i = requester i takes its result.
- `rsp_sum`  out  32  registered sum.
- `rsp_cout`  out  1  registered carry-out.
- `rsp_ovf`  out  1  signed overflow; present only with `CSLA32_ARB_OVF_EN`.

## Operation
The FSM has three states: IDLE, EXEC, RESP.

**IDLE**
- Winner selection:
  - Only one `req_valid` bit set: that requester wins.
  - Both bits set: requester `prio` wins.
- `req_ready[w]` = 1 for the winner w only. This output is combinational on `req_valid`, `state` and `prio`.
- On a handshake:
  - Latch a, b, cin and the grant index g into operand registers.
  - Set `prio` to the loser (1-g).
  - Go to EXEC.
- With no handshake, stay in IDLE.

**EXEC**
- The adder is fed only from the operand registers.
- Register `rsp_sum` and `rsp_cout` from the adder output.
- Set `rsp_valid` = one-hot(g) and go to RESP.

**RESP**
- `rsp_valid`, `rsp_sum`, `rsp_cout` and `rsp_ovf` stay stable.
- When `rsp_ready[g]` = 1: clear `rsp_valid` and go to IDLE.
- `rsp_ready` of the non-granted requester is ignored.

Outside IDLE, `req_ready` = 2'b00. `req_*` inputs are ignored in EXEC and RESP.

Arithmetic:
- {`rsp_cout`, `rsp_sum`} = a + b + cin, computed mod 2^33.
- No sign extension.

Boundary conditions:
- A requester dropping `req_valid` before its handshake loses nothing. No state changes.
- Operands are never re-sampled after the handshake.
- `prio` changes only on a handshake made while both requesters were valid.
- A lone requester does not change `prio`.

## Timing
- Reset values, applied on the first edge with `rst` = 1:
  - state = IDLE, `prio` = 0 (requester 0 favored).
  - `rsp_valid` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_ovf` = 0.
  - `req_ready` is forced to 0 while `rst` is high.
- Latency: handshake in cycle N gives `rsp_valid` high from cycle N+2.
- Throughput: at most one operation per 3 cycles. The next handshake is possible at N+3 if `rsp_ready` is high in N+2.
- `rst` asserted in EXEC or RESP aborts the operation. No response is produced, and the block is in IDLE on the following cycle.
- The adder's combinational path must settle within one clock period. It launches from the operand registers and is captured by the result registers.

## Configuration
- `CSLA32_ARB_OVF_EN` defined:
  - `rsp_ovf` port exists.
  - It is registered in EXEC as (a[31] == b[31]) && (sum[31] != a[31]).
- Undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

## Test plan
- **Single request.** Requester 0 sends a=0xFFFFFFFF, b=0x00000001, cin=0 at cycle N. Required: `rsp_valid`=2'b01 at N+2, `rsp_sum`=0x00000000, `rsp_cout`=1.
- **Round-robin under contention.** Both requesters hold valid from reset. Required: grants go 0,1,0,1; requester 1 computes 0x12345678+0x0000FFFF, cin=1, giving `rsp_sum`=0x12355678 and `rsp_cout`=0.
- **Backpressure.** Hold `rsp_ready`=0 for 5 cycles in RESP. Required: `rsp_valid`, `rsp_sum` and `rsp_cout` stay constant, and `req_ready`=2'b00 throughout. Asserting `rsp_ready` of the wrong requester does not release the response.
- **Reset mid-operation.** Assert `rst` for 1 cycle in EXEC. Required:
  - No `rsp_valid` pulse.
  - All outputs return to reset values.
  - A new requester 1 request completes normally afterward.
- **Overflow, with `CSLA32_ARB_OVF_EN` defined.**
  - 0x7FFFFFFF+0x00000001 gives `rsp_ovf`=1, `rsp_cout`=0.
  - 0x80000000+0x80000000 gives `rsp_sum`=0, `rsp_cout`=1, `rsp_ovf`=1.
  - 0x00000005+0xFFFFFFFF gives `rsp_ovf`=0.
